// File: rtl/mips_exec_decode.sv
// Single-cycle MIPS decode + ALU-control + 32-bit ALU, all outputs registered.
// Optional: define MIPS_EXEC_BRANCH_EN to compute pc_src; otherwise it is tied to 0.
module mips_exec_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm_ext,
    output logic [31:0] result,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        cout,
    output logic        jump,
    output logic        mem_read,
    output logic        mem_write,
    output logic        alu_src,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  alu_op,
    output logic [2:0]  branch,
    output logic [3:0]  alu_ctrl,
    output logic        pc_src
);

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000, ALU_OR   = 4'b0001, ALU_ADD  = 4'b0010, ALU_XOR  = 4'b0011,
        ALU_SLL  = 4'b0100, ALU_SRL  = 4'b0101, ALU_SUB  = 4'b0110, ALU_SLT  = 4'b0111,
        ALU_SRA  = 4'b1000, ALU_LUI  = 4'b1001, ALU_ADDU = 4'b1010, ALU_SUBU = 4'b1011,
        ALU_NOR  = 4'b1100, ALU_SLTU = 4'b1101
    } alu_ctrl_e;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_shamt;
    logic        w_unused_fields;

    logic        w_jump, w_mem_read, w_mem_write, w_alu_src, w_reg_write;
    logic [1:0]  w_reg_dst, w_mem_to_reg;
    logic [2:0]  w_alu_op, w_branch;
    alu_ctrl_e   w_alu_ctrl;

    logic [31:0] w_a, w_b, w_result;
    logic [32:0] w_sum, w_diff;
    logic        w_cout, w_overflow, w_zero, w_negative, w_pc_src;

    assign w_op            = instr[31:26];
    assign w_shamt         = instr[10:6];
    assign w_funct         = instr[5:0];
    assign w_unused_fields = ^instr[25:11];

    always_comb begin
        w_jump       = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'b00;
        w_mem_to_reg = 2'b00;
        w_alu_op     = 3'b000;
        w_branch     = 3'b000;
        case (w_op)
            6'h00: begin w_reg_dst = 2'b01; w_reg_write = 1'b1; w_alu_op = 3'b010; end
            6'h23: begin
                w_alu_src = 1'b1; w_mem_read = 1'b1; w_mem_to_reg = 2'b01; w_reg_write = 1'b1;
            end
            6'h2B: begin w_alu_src = 1'b1; w_mem_write = 1'b1; end
            6'h04: begin w_branch = 3'b001; w_alu_op = 3'b001; end
            6'h05: begin w_branch = 3'b010; w_alu_op = 3'b001; end
            6'h01: begin w_branch = 3'b011; w_alu_op = 3'b001; end
            6'h06: begin w_branch = 3'b100; w_alu_op = 3'b001; end
            6'h07: begin w_branch = 3'b101; w_alu_op = 3'b001; end
            6'h08: begin w_alu_src = 1'b1; w_reg_write = 1'b1; end
            6'h0C: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 3'b011; end
            6'h0D: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 3'b100; end
            6'h0A: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 3'b101; end
            6'h0F: begin w_alu_src = 1'b1; w_reg_write = 1'b1; w_alu_op = 3'b110; end
            6'h02: begin w_jump = 1'b1; end
            6'h03: begin
                w_jump = 1'b1; w_reg_write = 1'b1; w_reg_dst = 2'b10; w_mem_to_reg = 2'b10;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_alu_op)
            3'b000: w_alu_ctrl = ALU_ADD;
            3'b001: w_alu_ctrl = ALU_SUB;
            3'b011: w_alu_ctrl = ALU_AND;
            3'b100: w_alu_ctrl = ALU_OR;
            3'b101: w_alu_ctrl = ALU_SLT;
            3'b110: w_alu_ctrl = ALU_LUI;
            3'b010: begin
                case (w_funct)
                    6'h20:   w_alu_ctrl = ALU_ADD;
                    6'h21:   w_alu_ctrl = ALU_ADDU;
                    6'h22:   w_alu_ctrl = ALU_SUB;
                    6'h23:   w_alu_ctrl = ALU_SUBU;
                    6'h24:   w_alu_ctrl = ALU_AND;
                    6'h25:   w_alu_ctrl = ALU_OR;
                    6'h26:   w_alu_ctrl = ALU_XOR;
                    6'h27:   w_alu_ctrl = ALU_NOR;
                    6'h2A:   w_alu_ctrl = ALU_SLT;
                    6'h2B:   w_alu_ctrl = ALU_SLTU;
                    6'h00:   w_alu_ctrl = ALU_SLL;
                    6'h02:   w_alu_ctrl = ALU_SRL;
                    6'h03:   w_alu_ctrl = ALU_SRA;
                    default: w_alu_ctrl = ALU_ADD;
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    assign w_a    = rs_data;
    assign w_b    = w_alu_src ? imm_ext : rt_data;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    // Subtraction as A + ~B + 1 so the carry out reads as "no borrow".
    assign w_diff = {1'b0, w_a} + {1'b0, ~w_b} + 33'd1;

    always_comb begin
        w_result   = '0;
        w_cout     = 1'b0;
        w_overflow = 1'b0;
        case (w_alu_ctrl)
            ALU_ADD: begin
                w_result   = w_sum[31:0];
                w_cout     = w_sum[32];
                w_overflow = (w_a[31] == w_b[31]) && (w_sum[31] != w_a[31]);
            end
            ALU_ADDU: begin
                w_result = w_sum[31:0];
                w_cout   = w_sum[32];
            end
            ALU_SUB: begin
                w_result   = w_diff[31:0];
                w_cout     = w_diff[32];
                w_overflow = (w_a[31] != w_b[31]) && (w_diff[31] != w_a[31]);
            end
            ALU_SUBU: begin
                w_result = w_diff[31:0];
                w_cout   = w_diff[32];
            end
            ALU_AND:  w_result = w_a & w_b;
            ALU_OR:   w_result = w_a | w_b;
            ALU_XOR:  w_result = w_a ^ w_b;
            ALU_NOR:  w_result = ~(w_a | w_b);
            ALU_SLT:  w_result = {31'b0, ($signed(w_a) < $signed(w_b))};
            ALU_SLTU: w_result = {31'b0, (w_a < w_b)};
            ALU_SLL:  w_result = w_b << w_shamt;
            ALU_SRL:  w_result = w_b >> w_shamt;
            ALU_SRA:  w_result = $unsigned($signed(w_b) >>> w_shamt);
            ALU_LUI:  w_result = {w_b[15:0], 16'h0000};
            default:  w_result = '0;
        endcase
    end

    assign w_zero     = (w_result == 32'd0);
    assign w_negative = w_result[31];

`ifdef MIPS_EXEC_BRANCH_EN
    always_comb begin
        w_pc_src = 1'b0;
        case (w_branch)
            3'b001:  w_pc_src = w_zero;
            3'b010:  w_pc_src = !w_zero;
            3'b011:  w_pc_src = !w_negative;
            3'b100:  w_pc_src = w_zero | w_negative;
            3'b101:  w_pc_src = !w_zero && !w_negative;
            default: w_pc_src = 1'b0;
        endcase
    end
`else
    assign w_pc_src = 1'b0;
`endif

    logic [31:0] r_result;
    logic        r_zero, r_negative, r_overflow, r_cout;
    logic        r_jump, r_mem_read, r_mem_write, r_alu_src, r_reg_write;
    logic [1:0]  r_reg_dst, r_mem_to_reg;
    logic [2:0]  r_alu_op, r_branch;
    logic [3:0]  r_alu_ctrl;
    logic        r_pc_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_negative   <= 1'b0;
            r_overflow   <= 1'b0;
            r_cout       <= 1'b0;
            r_jump       <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_reg_dst    <= '0;
            r_mem_to_reg <= '0;
            r_alu_op     <= '0;
            r_branch     <= '0;
            r_alu_ctrl   <= '0;
            r_pc_src     <= 1'b0;
        end else begin
            r_result     <= w_result;
            r_zero       <= w_zero;
            r_negative   <= w_negative;
            r_overflow   <= w_overflow;
            r_cout       <= w_cout;
            r_jump       <= w_jump;
            r_mem_read   <= w_mem_read;
            r_mem_write  <= w_mem_write;
            r_alu_src    <= w_alu_src;
            r_reg_write  <= w_reg_write;
            r_reg_dst    <= w_reg_dst;
            r_mem_to_reg <= w_mem_to_reg;
            r_alu_op     <= w_alu_op;
            r_branch     <= w_branch;
            r_alu_ctrl   <= w_alu_ctrl;
            r_pc_src     <= w_pc_src;
        end
    end

    assign result     = r_result;
    assign zero       = r_zero;
    assign negative   = r_negative;
    assign overflow   = r_overflow;
    assign cout       = r_cout;
    assign jump       = r_jump;
    assign mem_read   = r_mem_read;
    assign mem_write  = r_mem_write;
    assign alu_src    = r_alu_src;
    assign reg_write  = r_reg_write;
    assign reg_dst    = r_reg_dst;
    assign mem_to_reg = r_mem_to_reg;
    assign alu_op     = r_alu_op;
    assign branch     = r_branch;
    assign alu_ctrl   = r_alu_ctrl;
    assign pc_src     = r_pc_src;

endmodule

// File: tb/tb_mips_exec_decode.sv
// Directed-vector bench for mips_exec_decode; pc_src expectations follow MIPS_EXEC_BRANCH_EN.
module tb_mips_exec_decode;

`ifdef MIPS_EXEC_BRANCH_EN
    localparam logic BR_EN = 1'b1;
`else
    localparam logic BR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] instr, rs_data, rt_data, imm_ext;
    logic [31:0] result;
    logic        zero, negative, overflow, cout;
    logic        jump, mem_read, mem_write, alu_src, reg_write;
    logic [1:0]  reg_dst, mem_to_reg;
    logic [2:0]  alu_op, branch;
    logic [3:0]  alu_ctrl;
    logic        pc_src;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    mips_exec_decode dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .imm_ext(imm_ext), .result(result), .zero(zero), .negative(negative),
        .overflow(overflow), .cout(cout), .jump(jump), .mem_read(mem_read),
        .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_op(alu_op), .branch(branch), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flat views: control = {jump,mem_read,mem_write,alu_src,reg_write,reg_dst,mem_to_reg,alu_op,branch}
    logic [14:0] w_ctl;
    logic [3:0]  w_flags;
    logic [55:0] w_all;
    assign w_ctl   = {jump, mem_read, mem_write, alu_src, reg_write, reg_dst, mem_to_reg, alu_op, branch};
    assign w_flags = {zero, negative, overflow, cout};
    assign w_all   = {result, w_flags, w_ctl, alu_ctrl, pc_src};

    function automatic logic [14:0] ctl(input logic j, mr, mw, as, rw,
                                        input logic [1:0] rd, mtr, input logic [2:0] aop, br);
        return {j, mr, mw, as, rw, rd, mtr, aop, br};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, 15'h0000, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op);
        return {op, 26'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [31:0] i, input logic [31:0] a, b, imm);
        instr   = i;
        rs_data = a;
        rt_data = b;
        imm_ext = imm;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b1;
        instr   = rtype(5'd0, 6'h20);
        rs_data = 32'h7FFF_FFFF;
        rt_data = 32'h1;
        imm_ext = 32'h1234;
        #1 rst_n = 1'b0;
        #1 chk("reset_async", 64'(w_all), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("reset_hold", 64'(w_all), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        apply(rtype(5'd0, 6'h20), 32'h7FFF_FFFF, 32'h1, 32'hFFFF_FFFF);
        chk("add_res", 64'(result), 64'h8000_0000);
        chk("add_flags", 64'(w_flags), 64'b0110);
        chk("add_ctl", 64'(w_ctl), 64'(ctl(0,0,0,0,1,2'b01,2'b00,3'b010,3'b000)));
        chk("add_aluctrl", 64'(alu_ctrl), 64'b0010);

        apply(rtype(5'd0, 6'h21), 32'h7FFF_FFFF, 32'h1, 32'h0);
        chk("addu_res", 64'(result), 64'h8000_0000);
        chk("addu_flags", 64'(w_flags), 64'b0100);
        chk("addu_aluctrl", 64'(alu_ctrl), 64'b1010);

        apply(rtype(5'd0, 6'h22), 32'd5, 32'd5, 32'h0);
        chk("sub_res", 64'(result), 64'h0);
        chk("sub_flags", 64'(w_flags), 64'b1001);
        chk("sub_aluctrl", 64'(alu_ctrl), 64'b0110);

        apply(rtype(5'd0, 6'h22), 32'h8000_0000, 32'h1, 32'h0);
        chk("subov_res", 64'(result), 64'h7FFF_FFFF);
        chk("subov_flags", 64'(w_flags), 64'b0011);

        apply(itype(6'h04), 32'd5, 32'd5, 32'd100);
        chk("beq_ctl", 64'(w_ctl), 64'(ctl(0,0,0,0,0,2'b00,2'b00,3'b001,3'b001)));
        chk("beq_pc", 64'(pc_src), 64'(BR_EN));
        chk("beq_zero", 64'(zero), 64'd1);

        apply(itype(6'h05), 32'd5, 32'd5, 32'd100);
        chk("bne_ctl", 64'(w_ctl), 64'(ctl(0,0,0,0,0,2'b00,2'b00,3'b001,3'b010)));
        chk("bne_pc", 64'(pc_src), 64'd0);

        apply(itype(6'h01), 32'd3, 32'd5, 32'd0);
        chk("bgez_neg_pc", 64'(pc_src), 64'd0);
        apply(itype(6'h01), 32'd5, 32'd5, 32'd0);
        chk("bgez_eq_pc", 64'(pc_src), 64'(BR_EN));
        apply(itype(6'h06), 32'd3, 32'd5, 32'd0);
        chk("blez_pc", 64'(pc_src), 64'(BR_EN));
        chk("blez_branch", 64'(branch), 64'b100);
        apply(itype(6'h07), 32'd5, 32'd5, 32'd0);
        chk("bgtz_eq_pc", 64'(pc_src), 64'd0);
        apply(itype(6'h07), 32'd6, 32'd5, 32'd0);
        chk("bgtz_gt_pc", 64'(pc_src), 64'(BR_EN));
        chk("bgtz_branch", 64'(branch), 64'b101);

        apply(itype(6'h23), 32'h1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("lw_res", 64'(result), 64'h0000_0FFC);
        chk("lw_ctl", 64'(w_ctl), 64'(ctl(0,1,0,1,1,2'b00,2'b01,3'b000,3'b000)));
        chk("lw_flags", 64'(w_flags), 64'b0001);

        apply(itype(6'h2B), 32'h20, 32'h0, 32'h8);
        chk("sw_ctl", 64'(w_ctl), 64'(ctl(0,0,1,1,0,2'b00,2'b00,3'b000,3'b000)));
        chk("sw_res", 64'(result), 64'h28);

        apply(rtype(5'd4, 6'h03), 32'h0, 32'hF000_0000, 32'h0);
        chk("sra_res", 64'(result), 64'hFF00_0000);
        chk("sra_aluctrl", 64'(alu_ctrl), 64'b1000);
        apply(rtype(5'd4, 6'h02), 32'h0, 32'hF000_0000, 32'h0);
        chk("srl_res", 64'(result), 64'h0F00_0000);
        apply(rtype(5'd31, 6'h00), 32'h0, 32'h1, 32'h0);
        chk("sll_res", 64'(result), 64'h8000_0000);

        apply(rtype(5'd0, 6'h2A), 32'hFFFF_FFFF, 32'h1, 32'h0);
        chk("slt_res", 64'(result), 64'h1);
        chk("slt_aluctrl", 64'(alu_ctrl), 64'b0111);
        apply(rtype(5'd0, 6'h2B), 32'hFFFF_FFFF, 32'h1, 32'h0);
        chk("sltu_res", 64'(result), 64'h0);
        chk("sltu_zero", 64'(zero), 64'd1);

        apply(rtype(5'd0, 6'h27), 32'h0, 32'h0, 32'h0);
        chk("nor_res", 64'(result), 64'hFFFF_FFFF);
        apply(rtype(5'd0, 6'h3F), 32'd7, 32'd8, 32'h0);
        chk("badfunct_res", 64'(result), 64'd15);

        apply(itype(6'h0F), 32'hFFFF, 32'h0, 32'h0000_1234);
        chk("lui_res", 64'(result), 64'h1234_0000);
        chk("lui_aluctrl", 64'(alu_ctrl), 64'b1001);
        apply(itype(6'h0D), 32'h00F0, 32'hFFFF, 32'h0F0F);
        chk("ori_res", 64'(result), 64'h0FFF);
        chk("ori_alu_op", 64'(alu_op), 64'b100);

        apply(itype(6'h03), 32'h0, 32'h0, 32'h0);
        chk("jal_ctl", 64'(w_ctl), 64'(ctl(1,0,0,0,1,2'b10,2'b10,3'b000,3'b000)));
        apply(itype(6'h3F), 32'h1, 32'h2, 32'h3);
        chk("badop_ctl", 64'(w_ctl), 64'd0);
        chk("badop_pc", 64'(pc_src), 64'd0);

        apply(rtype(5'd0, 6'h20), 32'h10, 32'h20, 32'h0);
        chk("pre_rst_res", 64'(result), 64'h30);
        #2 rst_n = 1'b0;
        #1 chk("midrst_async", 64'(w_all), 64'd0);
        @(posedge clk); #1;
        chk("midrst_hold", 64'(w_all), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        apply(itype(6'h08), 32'd40, 32'd0, 32'd2);
        chk("addi_after_rst", 64'(result), 64'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_exec_decode.md
# mips_exec_decode

Combined decode-and-execute stage for the single-cycle MIPS datapath. It merges the main control unit, the ALU-control decoder and the 32-bit ALU. It decodes a 32-bit instruction, selects the ALU operands, computes the result, flags and branch decision, and registers everything for the next stage. It sits between the register file / sign-extender and the data memory / PC-select logic.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word; op=[31:26], shamt=[10:6], funct=[5:0]
- rs_data  in  32  register-file read port one (ALU operand A)
- rt_data  in  32  register-file read port two
- imm_ext  in  32  sign/zero-extended immediate
- result  out  32  ALU result, registered
- zero, negative, overflow, cout  out  1 each  ALU flags, registered
- jump, mem_read, mem_write, alu_src, reg_write  out  1 each  control, registered
- reg_dst, mem_to_reg  out  2 each  control, registered
- alu_op, branch  out  3 each  control, registered
- alu_ctrl  out  4  decoded ALU operation, registered
- pc_src  out  1  branch taken, registered

## Operation
Main decode, by op; every field not listed is 0:
- 0x00 R-type: reg_dst=01, reg_write, alu_op=010
- 0x23 lw: alu_src, mem_read, mem_to_reg=01, reg_write, alu_op=000
- 0x2B sw: alu_src, mem_write, alu_op=000
- 0x04 beq: branch=001, alu_op=001
- 0x05 bne: branch=010, alu_op=001
- 0x01 bgez: branch=011, alu_op=001
- 0x06 blez: branch=100, alu_op=001
- 0x07 bgtz: branch=101, alu_op=001
- 0x08 addi: alu_src, reg_write, alu_op=000
- 0x0C andi: alu_src, reg_write, alu_op=011
- 0x0D ori: alu_src, reg_write, alu_op=100
- 0x0A slti: alu_src, reg_write, alu_op=101
- 0x0F lui: alu_src, reg_write, alu_op=110
- 0x02 j: jump
- 0x03 jal: jump, reg_write, reg_dst=10, mem_to_reg=10
- Any other op: all controls 0, which behaves as a NOP.

ALU-control mapping:
- alu_op 000 → ADD(0010); 001 → SUB(0110); 011 → AND(0000); 100 → OR(0001); 101 → SLT(0111); 110 → LUI(1001).
- alu_op 010 decodes funct: 0x20 ADD, 0x21 ADDU(1010), 0x22 SUB, 0x23 SUBU(1011), 0x24 AND, 0x25 OR, 0x26 XOR(0011), 0x27 NOR(1100), 0x2A SLT, 0x2B SLTU(1101), 0x00 SLL(0100), 0x02 SRL(0101), 0x03 SRA(1000).
- Unknown funct → ADD.

ALU:
- Operand B is imm_ext when alu_src=1, otherwise rt_data.
- Shifts shift B by shamt; SRA is arithmetic.
- LUI result is {B[15:0],16'h0}.
- SLT is a signed compare and SLTU an unsigned compare; both produce result 0 or 1.
- zero = (result==0).
- negative = result[31].
- cout = carry out of the 33-bit sum for ADD/ADDU. For SUB/SUBU it is A+~B+1, so cout=1 means no borrow. cout is 0 for all other ops.
- overflow is set only for signed ADD/SUB: operand signs agree (after B inversion for SUB) and the result sign differs. It is 0 for all other ops, including ADDU/SUBU.

pc_src, using the SUB flags:
- branch 001: zero
- branch 010: !zero
- branch 011: !negative
- branch 100: zero | negative
- branch 101: !zero & !negative
- otherwise: 0
- The sign test uses the raw result sign. Operands whose difference overflows are out of scope.

## Timing
- Decode, operand mux, ALU and branch evaluation are combinational. All outputs are captured on rising clk, so latency is 1 cycle from input to output.
- There is no handshake; a new instruction is accepted every cycle.
- When rst_n=0, all outputs go to 0 immediately. While rst_n is low, they stay 0 regardless of clk.
- Release of rst_n is synchronous to clk in the system. The first valid output appears on the first clock edge after release.
- Reset asserted mid-stream discards the in-flight result.

## Configuration
- MIPS_EXEC_BRANCH_EN defined: pc_src is computed as above.
- MIPS_EXEC_BRANCH_EN undefined: pc_src is tied to 0, and branch opcodes still decode their control fields. This is for designs where PC selection lives elsewhere.

## Test plan
- Reset: rst_n=0 with nonzero inputs → all outputs 0 without any clk edge; they stay 0 until release.
- add (op 0x00, funct 0x20), A=0x7FFFFFFF, B=1 → result 0x80000000, overflow=1, negative=1, reg_dst=01, alu_ctrl=0010. addu with the same operands → overflow=0.
- sub with A=5, B=5 → result 0, zero=1, cout=1. beq with the same operands → pc_src=1; bne → pc_src=0.
- lw, rs=0x1000, imm=0xFFFFFFFC → result 0x0FFC, mem_read=1, mem_to_reg=01, alu_src=1.
- sra shamt=4, rt=0xF0000000 → 0xFF000000. slt A=-1, B=1 → 1. sltu with the same operands → 0.
- jal → jump=1, reg_write=1, reg_dst=10, mem_to_reg=10. Unknown op 0x3F → all controls 0.
